vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 70 +++++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and derived totals.
// Used by vga_timing_gen and vga_axis_counter.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_BOTTOM_DEF  = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_TOP_DEF     = 33;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_DISPLAY_DEF, V_BOTTOM_DEF, V_SYNC_DEF, V_TOP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with carry-out, registered
// active-low sync decode and look-ahead active-region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int DISPLAY = H_DISPLAY_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    output cnt_t count,
    output logic carry,
    output logic sync_n,
    output logic next_active
);

    localparam cnt_t LAST_C       = cnt_t'(axis_total(DISPLAY, FRONT, SYNC, BACK) - 1);
    localparam cnt_t SYNC_FIRST_C = cnt_t'(DISPLAY + FRONT);
    localparam cnt_t SYNC_LAST_C  = cnt_t'(DISPLAY + FRONT + SYNC - 1);
    localparam cnt_t ACT_END_C    = cnt_t'(DISPLAY);

    cnt_t count_r;
    cnt_t count_next_s;
    logic carry_s;
    logic sync_n_r;
    logic sync_n_next_s;
    logic active_next_s;

    // Next position and wrap carry for this axis
    always_comb begin
        count_next_s = count_r;
        carry_s      = 1'b0;
        if (step) begin
            if (count_r == LAST_C) begin
                count_next_s = '0;
                carry_s      = 1'b1;
            end else begin
                count_next_s = count_r + 10'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Decode from the next position so registered outputs line up with count
    always_comb begin
        sync_n_next_s = !((count_next_s >= SYNC_FIRST_C) && (count_next_s <= SYNC_LAST_C));
        active_next_s = (count_next_s < ACT_END_C);
    end

    // Position and sync registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= '0;
            sync_n_r <= 1'b1;
        end else begin
            count_r  <= count_next_s;
            sync_n_r <= sync_n_next_s;
        end
    end

    assign count       = count_r;
    assign carry       = carry_s;
    assign sync_n      = sync_n_r;
    assign next_active = active_next_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator built from two vga_axis_counter instances.
// Optional frame counter enabled by macro VGA_FRAME_COUNTER_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_BOTTOM  = V_BOTTOM_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_TOP     = V_TOP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_start,
    output logic [9:0] frame_count
);

    logic h_carry_s;
    logic v_carry_s;
    logic h_active_next_s;
    logic v_active_next_s;
    logic display_on_r;
    logic display_on_next_s;
    logic frame_start_r;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk         (clk),
        .reset       (reset),
        .step        (pix_ce),
        .count       (hpos),
        .carry       (h_carry_s),
        .sync_n      (hsync),
        .next_active (h_active_next_s)
    );

    // Lines advance only on the pixel edge that wraps the horizontal axis
    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_BOTTOM),
        .SYNC    (V_SYNC),
        .BACK    (V_TOP)
    ) u_v_axis (
        .clk         (clk),
        .reset       (reset),
        .step        (h_carry_s),
        .count       (vpos),
        .carry       (v_carry_s),
        .sync_n      (vsync),
        .next_active (v_active_next_s)
    );

    // Visible-region flag for the upcoming position
    always_comb begin
        display_on_next_s = display_on_r;
        if (pix_ce) begin
            display_on_next_s = h_active_next_s & v_active_next_s;
        end else begin
            display_on_next_s = display_on_r;
        end
    end

    // frame_start is a single-clock pulse following the frame wrap edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_on_r  <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            display_on_r  <= display_on_next_s;
            frame_start_r <= v_carry_s;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [9:0] frame_count_r;

    // Completed-frame counter, wraps naturally at 1024
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_r <= 10'd0;
        end else if (v_carry_s) begin
            frame_count_r <= frame_count_r + 10'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`else
    assign frame_count = 10'd0;
`endif

    assign display_on  = display_on_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a small-raster instance checked cycle by cycle through a
// scoreboard queue, plus a default-timing instance checked over one full line.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       pix_ce;
    logic       pix_ce_d;

    logic [9:0] hpos, vpos, frame_count;
    logic       hsync, vsync, display_on, frame_start;
    logic [9:0] hpos_d, vpos_d, frame_count_d;
    logic       hsync_d, vsync_d, display_on_d, frame_start_d;

    // Small raster: 8 pixels x 6 lines, hsync at h 5..6, vsync at v 4
    vga_timing_gen #(
        .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_DISPLAY (3), .V_BOTTOM (1), .V_SYNC (1), .V_TOP (1)
    ) dut (
        .clk (clk), .reset (reset), .pix_ce (pix_ce),
        .hpos (hpos), .vpos (vpos), .hsync (hsync), .vsync (vsync),
        .display_on (display_on), .frame_start (frame_start),
        .frame_count (frame_count)
    );

    vga_timing_gen dut_def (
        .clk (clk), .reset (reset), .pix_ce (pix_ce_d),
        .hpos (hpos_d), .vpos (vpos_d), .hsync (hsync_d), .vsync (vsync_d),
        .display_on (display_on_d), .frame_start (frame_start_d),
        .frame_count (frame_count_d)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [9:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_h = 0, m_v = 0, m_fc = 0;
    logic m_fs = 1'b0;

    function automatic exp_t model_out();
        exp_t e;
        e.h  = 10'(m_h);
        e.v  = 10'(m_v);
        e.hs = !((m_h >= 5) && (m_h <= 6));
        e.vs = (m_v != 4);
        e.de = (m_h < 4) && (m_v < 3);
        e.fs = m_fs;
        e.fc = 10'(m_fc);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic compare_sb();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed 0 expected 1");
        end else begin
            e = sb_q.pop_front();
            chk("hpos", hpos, e.h);
            chk("vpos", vpos, e.v);
            chk("hsync", {9'd0, hsync}, {9'd0, e.hs});
            chk("vsync", {9'd0, vsync}, {9'd0, e.vs});
            chk("display_on", {9'd0, display_on}, {9'd0, e.de});
            chk("frame_start", {9'd0, frame_start}, {9'd0, e.fs});
            chk("frame_count", frame_count, e.fc);
        end
    endtask

    task automatic model_reset();
        m_h  = 0;
        m_v  = 0;
        m_fc = 0;
        m_fs = 1'b0;
    endtask

    task automatic step(input logic ce);
        pix_ce = ce;
        m_fs   = 1'b0;
        if (ce) begin
            if (m_h == 7) begin
                m_h = 0;
                if (m_v == 5) begin
                    m_v  = 0;
                    m_fs = 1'b1;
`ifdef VGA_FRAME_COUNTER_EN
                    m_fc = (m_fc + 1) % 1024;
`endif
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_sb();
    endtask

    initial begin
        int hs_lows;
        int first_low;
        int eh;
        int guard;

        reset    = 1'b1;
        pix_ce   = 1'b0;
        pix_ce_d = 1'b0;
        model_reset();
        #12;
        sb_q.push_back(model_out());
        compare_sb();
        chk("def_reset_hpos", hpos_d, 10'd0);
        chk("def_reset_hsync", {9'd0, hsync_d}, 10'd1);
        @(negedge clk);
        reset = 1'b0;

        // Default timing: one full line plus the wrap
        hs_lows   = 0;
        first_low = -1;
        pix_ce_d  = 1'b1;
        for (int i = 0; i < 801; i++) begin
            @(posedge clk);
            #1;
            eh = (i + 1) % 800;
            chk("def_hpos", hpos_d, 10'(eh));
            chk("def_vpos", vpos_d, (i + 1 >= 800) ? 10'd1 : 10'd0);
            chk("def_hsync", {9'd0, hsync_d}, ((eh >= 656) && (eh <= 751)) ? 10'd0 : 10'd1);
            chk("def_display_on", {9'd0, display_on_d}, (eh < 640) ? 10'd1 : 10'd0);
            chk("def_vsync", {9'd0, vsync_d}, 10'd1);
            chk("def_frame_start", {9'd0, frame_start_d}, 10'd0);
            chk("def_frame_count", frame_count_d, 10'd0);
            if (!hsync_d) begin
                hs_lows++;
                if (first_low < 0) first_low = eh;
            end
        end
        pix_ce_d = 1'b0;
        chk("def_hsync_width", 10'(hs_lows), 10'd96);
        chk("def_hsync_start", 10'(first_low), 10'd656);

        // Small raster: first steps after reset, stalls, two full frames
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 96; i++) step(1'b1);

        // Alternating enable across two frames
        for (int i = 0; i < 96; i++) begin
            step(1'b1);
            step(1'b0);
        end

        // Wrap corner followed by a stall: pulse must not persist
        guard = 0;
        while (!((m_h == 7) && (m_v == 5)) && guard < 100) begin
            step(1'b1);
            guard++;
        end
        chk("corner_reached", 10'(guard < 100), 10'd1);
        step(1'b1);
        step(1'b0);
        step(1'b0);

        // Asynchronous reset in the middle of both sync pulses
        guard = 0;
        while (!((m_h == 6) && (m_v == 4)) && guard < 100) begin
            step(1'b1);
            guard++;
        end
        chk("midsync_reached", 10'(guard < 100), 10'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        sb_q.push_back(model_out());
        compare_sb();
        @(negedge clk);
        reset = 1'b0;

        // 1024 frames: counter wraps back to zero when enabled
        for (int i = 0; i < 1024 * 48; i++) step(1'b1);
        chk("frame_count_wrap", frame_count, 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
